// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO using all DEPTH entries, with occupancy count, programmable
// almost-full/almost-empty, overflow/underflow pulses and optional FWFT read mode.
module sync_fifo_flags #(
  parameter int DW       = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = 0,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_accept;
  logic          rd_accept;

  assign wr_addr = wr_ptr[AW-1:0];
  assign rd_addr = rd_ptr[AW-1:0];

  // Extra pointer MSB distinguishes full from empty when addresses coincide.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_addr == rd_addr);
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Pointers and error pulses; reset overrides any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + CW'(1);
      if (rd_accept) rd_ptr <= rd_ptr + CW'(1);
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
    end
  end

  // Storage is not cleared on reset, but a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) mem[wr_addr] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem[rd_addr];
    assign rd_valid = !empty;
  end else begin : g_reg
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;

    // Registered read: data lands one cycle after an accepted pop, else holds.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_accept;
        if (rd_accept) rd_data_q <= mem[rd_addr];
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: one registered-read instance and one FWFT instance.
module tb_sync_fifo_flags;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, wr_en, rd_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   count;

  logic          f_reset, f_wr_en, f_rd_en;
  logic [DW-1:0] f_wr_data;
  logic [DW-1:0] f_rd_data;
  logic          f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [AW:0]   f_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow));

  sync_fifo_flags #(.DW(DW), .DEPTH(DEPTH), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) u_fwft (
    .clk(clk), .reset(f_reset), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    f_reset = 1'b1; f_wr_en = 1'b0; f_rd_en = 1'b0; f_wr_data = '0;
    step();
    step();
    reset = 1'b0; f_reset = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);

    // Fill with 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      chk("fill_count", 32'(count), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 12) ? 1 : 0);
      chk("fill_ae", 32'(almost_empty), (i <= 4) ? 1 : 0);
      chk("fill_full", 32'(full), (i == 16) ? 1 : 0);
    end

    // Write while full is rejected with a one-cycle overflow pulse
    wr_data = 8'hAA;
    step();
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    wr_en = 1'b0;
    step();
    chk("ovf_clear", 32'(overflow), 0);
    chk("ovf_full", 32'(full), 1);

    // Drain: each word appears the cycle after its read
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      step();
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_data", 32'(rd_data), 32'(i));
    end
    rd_en = 1'b0;
    step();
    chk("drain_empty", 32'(empty), 1);
    chk("drain_count", 32'(count), 0);
    chk("drain_valid_low", 32'(rd_valid), 0);
    chk("drain_hold", 32'(rd_data), 32'h10);

    // Underflow on empty read
    rd_en = 1'b1;
    step();
    chk("unf_pulse", 32'(underflow), 1);
    chk("unf_valid", 32'(rd_valid), 0);
    chk("unf_count", 32'(count), 0);
    rd_en = 1'b0;
    step();
    chk("unf_clear", 32'(underflow), 0);

    // Simultaneous write+read on empty: write only
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h77;
    step();
    chk("wr_rd_empty_count", 32'(count), 1);
    chk("wr_rd_empty_unf", 32'(underflow), 1);
    chk("wr_rd_empty_valid", 32'(rd_valid), 0);
    q.push_back(8'h77);
    rd_en = 1'b0;

    // Bring occupancy to 8
    for (int i = 1; i <= 7; i++) begin
      wr_data = 8'(8'h80 + i);
      q.push_back(wr_data);
      step();
    end
    wr_en = 1'b0;
    step();
    chk("lvl8_count", 32'(count), 8);

    // Streaming at constant occupancy across pointer wrap
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'hA0 + k);
      q.push_back(wr_data);
      exp_d = q.pop_front();
      step();
      chk("stream_count", 32'(count), 8);
      chk("stream_valid", 32'(rd_valid), 1);
      chk("stream_data", 32'(rd_data), 32'(exp_d));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    step();

    // Reset mid-operation with a concurrent write
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      step();
    end
    chk("pre_rst_count", 32'(count), 10);
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    step();
    reset = 1'b0; wr_en = 1'b0;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_valid", 32'(rd_valid), 0);
    step();
    chk("midrst_count2", 32'(count), 0);

    // FWFT instance: head visible without a read request
    chk("fwft_rst_valid", 32'(f_rd_valid), 0);
    chk("fwft_rst_empty", 32'(f_empty), 1);
    f_wr_en = 1'b1; f_wr_data = 8'h5A;
    step();
    chk("fwft_valid", 32'(f_rd_valid), 1);
    chk("fwft_data", 32'(f_rd_data), 32'h5A);
    f_wr_data = 8'h6B;
    step();
    f_wr_en = 1'b0;
    chk("fwft_head_held", 32'(f_rd_data), 32'h5A);
    chk("fwft_count2", 32'(f_count), 2);
    f_rd_en = 1'b1;
    step();
    chk("fwft_pop1_data", 32'(f_rd_data), 32'h6B);
    chk("fwft_pop1_valid", 32'(f_rd_valid), 1);
    step();
    f_rd_en = 1'b0;
    chk("fwft_empty", 32'(f_empty), 1);
    chk("fwft_valid_low", 32'(f_rd_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
